// File: rtl/trap_controller.sv
// trap_controller: coordinates exceptions, external interrupts and MRET at
// writeback into a single redirect + flush sequence toward fetch and the CSR file.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// IDLE     | watching writeback for an exception, interrupt or MRET
// REDIRECT | one cycle: fetch redirect, CSR trap strobe, flush starts
// DRAIN    | flush held for DRAIN_CYCLES cycles while wrong-path work drains
module trap_controller #(
  parameter int         DRAIN_CYCLES  = 3,
  parameter logic [3:0] CAUSE_EXT_IRQ = 4'd11
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wbValid,
  input  logic [31:0] wbPC,
  input  logic        wbExceptionPending,
  input  logic [3:0]  wbExceptionCause,
  input  logic [31:0] wbExceptionValue,
  input  logic        wbMret,
  input  logic        interrupt,
  input  logic        mstatusMIE,
  input  logic [31:0] trapVector,
  input  logic [31:0] mepc,
  output logic        controlReset,
  output logic [3:0]  mcause,
  output logic        mcauseInterrupt,
  output logic [31:0] mtval,
  output logic [31:0] trapEPC,
  output logic        redirectValid,
  output logic [31:0] redirectPC,
  output logic        flush,
  output logic        retireSuppress
);

  // Counter only has to hold DRAIN_CYCLES-1 (terminal count is zero).
  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] drainCount;
  logic          irqPending;

  logic isIdle;
  logic irqReady;
  logic takeExc;
  logic takeIrq;
  logic takeMret;
  logic takeAny;

  // Targets are word aligned; the low bits of MTVEC/MEPC never reach fetch.
  logic unused_bits;
  assign unused_bits = ^{trapVector[1:0], mepc[1:0]};

  // Event decode with exception > interrupt > MRET priority, IDLE only.
  always_comb begin
    isIdle   = (state == IDLE);
    irqReady = irqPending && mstatusMIE;
    takeExc  = isIdle && wbValid && wbExceptionPending;
    takeIrq  = isIdle && wbValid && !wbExceptionPending && irqReady;
    takeMret = isIdle && wbValid && !wbExceptionPending && !irqReady && wbMret;
    takeAny  = takeExc || takeIrq || takeMret;
  end

  // A faulting instruction must not be counted as retired.
  assign retireSuppress = takeExc;

  // Interrupt request latch; a taken interrupt clears it even if the line is
  // still high, and a dropped line only clears it while IDLE so a request seen
  // during a drain is not lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      irqPending <= 1'b0;
    end else if (takeIrq) begin
      irqPending <= 1'b0;
    end else if (interrupt && mstatusMIE) begin
      irqPending <= 1'b1;
    end else if (isIdle && !interrupt) begin
      irqPending <= 1'b0;
    end
  end

  // Trap sequencer: latches cause/target in IDLE, redirects, then drains.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      drainCount      <= '0;
      controlReset    <= 1'b0;
      mcause          <= 4'd0;
      mcauseInterrupt <= 1'b0;
      mtval           <= 32'd0;
      trapEPC         <= 32'd0;
      redirectValid   <= 1'b0;
      redirectPC      <= 32'd0;
      flush           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          controlReset  <= 1'b0;
          redirectValid <= 1'b0;
          flush         <= 1'b0;
          if (takeAny) begin
            state         <= REDIRECT;
            redirectValid <= 1'b1;
            flush         <= 1'b1;
            controlReset  <= takeExc || takeIrq;
            redirectPC    <= takeMret ? {mepc[31:2], 2'b00}
                                      : {trapVector[31:2], 2'b00};
            if (takeExc) begin
              mcause          <= wbExceptionCause;
              mcauseInterrupt <= 1'b0;
              mtval           <= wbExceptionValue;
              trapEPC         <= wbPC;
            end else if (takeIrq) begin
              mcause          <= CAUSE_EXT_IRQ;
              mcauseInterrupt <= 1'b1;
              mtval           <= 32'd0;
              trapEPC         <= wbPC + 32'd4;
            end
          end
        end
        REDIRECT: begin
          state         <= DRAIN;
          controlReset  <= 1'b0;
          redirectValid <= 1'b0;
          flush         <= 1'b1;
          drainCount    <= CW'(DRAIN_CYCLES - 1);
        end
        DRAIN: begin
          controlReset  <= 1'b0;
          redirectValid <= 1'b0;
          if (drainCount == '0) begin
            state <= IDLE;
            flush <= 1'b0;
          end else begin
            drainCount <= drainCount - CW'(1);
          end
        end
        default: begin
          state         <= IDLE;
          controlReset  <= 1'b0;
          redirectValid <= 1'b0;
          flush         <= 1'b0;
        end
      endcase
    end
  end

endmodule
